// File: rtl/jt1942_rom_arb_pkg.sv
// rtl/jt1942_rom_arb_pkg.sv - shared FSM state codes and client indices for the ROM arbiter
package jt1942_rom_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACK  = 2'd1,
        ST_DATA = 2'd2
    } arb_state_e;

    typedef enum logic [1:0] {
        CLI_MAIN = 2'd0,
        CLI_SND  = 2'd1,
        CLI_CHAR = 2'd2,
        CLI_SCR  = 2'd3
    } cli_e;

endpackage

// File: rtl/jt1942_rom_slot.sv
// rtl/jt1942_rom_slot.sv - one-entry addr/data cache for a single ROM client with registered ok
module jt1942_rom_slot
    import jt1942_rom_arb_pkg::*;
#(
    parameter int AW = 22,
    parameter int DW = 8
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          cs,
    input  logic [AW-1:0] addr,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    output logic          hit,
    output logic          ok,
    output logic [DW-1:0] data
);

    logic          valid_q, valid_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] data_q, data_d;
    logic          ok_q, ok_d;

    always_comb begin
        hit     = valid_q && (addr_q == addr);
        valid_d = valid_q | wr_en;
        addr_d  = wr_en ? wr_addr : addr_q;
        data_d  = wr_en ? wr_data : data_q;
        // A fill lands in the same edge as ok, so ok follows rdy by one cycle
        ok_d    = cs && (wr_en ? (wr_addr == addr) : hit);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            ok_q    <= 1'b0;
        end else begin
            valid_q <= valid_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            ok_q    <= ok_d;
        end
    end

    assign ok   = ok_q;
    assign data = data_q;

endmodule

// File: rtl/jt1942_rom_arb.sv
// rtl/jt1942_rom_arb.sv - four-client ROM arbiter with per-client caches on one SDRAM read port
// Define JT1942_ROMARB_RR_EN for round-robin arbitration instead of fixed priority.
module jt1942_rom_arb
    import jt1942_rom_arb_pkg::*;
#(
    parameter int AW   = 22,
    parameter int DW   = 8,
    parameter int NCLI = 4
)(
    input  logic               clk,
    input  logic               rst,
    input  logic [NCLI-1:0]    cli_cs,
    input  logic [NCLI*AW-1:0] cli_addr,
    output logic [NCLI-1:0]    cli_ok,
    output logic [NCLI*DW-1:0] cli_data,
    output logic               sdram_req,
    output logic [AW-1:0]      sdram_addr,
    input  logic               sdram_ack,
    input  logic               sdram_rdy,
    input  logic [DW-1:0]      sdram_data
);

    localparam int IW = $clog2(NCLI);

    logic [AW-1:0]   caddr [NCLI];
    logic [NCLI-1:0] hit, miss, wr_en;
    logic            wr_stb, grant_vld;
    logic [IW-1:0]   grant_idx;

    arb_state_e      st_q, st_d;
    logic            req_q, req_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [IW-1:0]   win_q, win_d;

    // rdy coinciding with ack counts as the data beat
    assign wr_stb = sdram_rdy && ((st_q == ST_DATA) || (st_q == ST_ACK && sdram_ack));

    genvar gi;
    generate
        for (gi = 0; gi < NCLI; gi++) begin : g_slot
            assign caddr[gi] = cli_addr[gi*AW +: AW];
            assign miss[gi]  = cli_cs[gi] & ~hit[gi];
            assign wr_en[gi] = wr_stb && (win_q == IW'(gi));

            jt1942_rom_slot #(.AW(AW), .DW(DW)) u_slot (
                .clk     (clk),
                .rst     (rst),
                .cs      (cli_cs[gi]),
                .addr    (caddr[gi]),
                .wr_en   (wr_en[gi]),
                .wr_addr (addr_q),
                .wr_data (sdram_data),
                .hit     (hit[gi]),
                .ok      (cli_ok[gi]),
                .data    (cli_data[gi*DW +: DW])
            );
        end
    endgenerate

`ifdef JT1942_ROMARB_RR_EN
    logic [IW-1:0] ptr_q, ptr_d;

    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        // Walk downwards so the nearest client after the pointer wins
        for (int k = NCLI; k >= 1; k--) begin
            if (miss[(int'(ptr_q) + k) % NCLI]) begin
                grant_vld = 1'b1;
                grant_idx = IW'((int'(ptr_q) + k) % NCLI);
            end
        end
        ptr_d = (st_q == ST_IDLE && grant_vld) ? grant_idx : ptr_q;
    end
`else
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int i = NCLI - 1; i >= 0; i--) begin
            if (miss[i]) begin
                grant_vld = 1'b1;
                grant_idx = IW'(i);
            end
        end
    end
`endif

    always_comb begin
        st_d   = st_q;
        req_d  = req_q;
        addr_d = addr_q;
        win_d  = win_q;
        case (st_q)
            ST_IDLE: begin
                if (grant_vld) begin
                    st_d   = ST_ACK;
                    req_d  = 1'b1;
                    addr_d = caddr[grant_idx];
                    win_d  = grant_idx;
                end
            end
            ST_ACK: begin
                if (sdram_ack) begin
                    req_d = 1'b0;
                    st_d  = sdram_rdy ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (sdram_rdy) st_d = ST_IDLE;
            end
            default: st_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q   <= ST_IDLE;
            req_q  <= 1'b0;
            addr_q <= '0;
            win_q  <= '0;
`ifdef JT1942_ROMARB_RR_EN
            ptr_q  <= IW'(NCLI - 1);
`endif
        end else begin
            st_q   <= st_d;
            req_q  <= req_d;
            addr_q <= addr_d;
            win_q  <= win_d;
`ifdef JT1942_ROMARB_RR_EN
            ptr_q  <= ptr_d;
`endif
        end
    end

    assign sdram_req  = req_q;
    assign sdram_addr = addr_q;

endmodule

// File: tb/tb_jt1942_rom_arb.sv
// tb/tb_jt1942_rom_arb.sv - self-checking bench for jt1942_rom_arb with a reference cache model
module tb_jt1942_rom_arb;

    localparam int AW   = 22;
    localparam int DW   = 8;
    localparam int NCLI = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [NCLI-1:0]    cli_cs = '0;
    logic [NCLI*AW-1:0] cli_addr = '0;
    logic [NCLI-1:0]    cli_ok;
    logic [NCLI*DW-1:0] cli_data;
    logic               sdram_req;
    logic [AW-1:0]      sdram_addr;
    logic               sdram_ack = 1'b0;
    logic               sdram_rdy = 1'b0;
    logic [DW-1:0]      sdram_data = '0;

    int checks = 0;
    int errors = 0;
    int req_pulses = 0;
    logic req_prev = 1'b0;

    logic          drv_cs   [NCLI];
    logic [AW-1:0] drv_addr [NCLI];
    bit            ref_valid[NCLI];
    logic [AW-1:0] ref_addr [NCLI];
    int            ref_last;

    jt1942_rom_arb #(.AW(AW), .DW(DW), .NCLI(NCLI)) dut (
        .clk        (clk),
        .rst        (rst),
        .cli_cs     (cli_cs),
        .cli_addr   (cli_addr),
        .cli_ok     (cli_ok),
        .cli_data   (cli_data),
        .sdram_req  (sdram_req),
        .sdram_addr (sdram_addr),
        .sdram_ack  (sdram_ack),
        .sdram_rdy  (sdram_rdy),
        .sdram_data (sdram_data)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (sdram_req && !req_prev) req_pulses++;
        req_prev = sdram_req;
    end

    function automatic logic [DW-1:0] mem(input logic [AW-1:0] a);
        return 8'(a[7:0] * 8'd7 + a[15:8] + 8'hA4);
    endfunction

    function automatic bit ref_hit(input int c);
        return ref_valid[c] && (ref_addr[c] == drv_addr[c]);
    endfunction

    function automatic int ref_pick();
`ifdef JT1942_ROMARB_RR_EN
        for (int k = 1; k <= NCLI; k++)
            if (drv_cs[(ref_last + k) % NCLI] && !ref_hit((ref_last + k) % NCLI))
                return (ref_last + k) % NCLI;
`else
        for (int c = 0; c < NCLI; c++)
            if (drv_cs[c] && !ref_hit(c)) return c;
`endif
        return -1;
    endfunction

    task automatic ref_grant(input int c, input logic [AW-1:0] a);
        ref_valid[c] = 1'b1;
        ref_addr[c]  = a;
        ref_last     = c;
    endtask

    task automatic ref_clear();
        for (int c = 0; c < NCLI; c++) begin
            ref_valid[c] = 1'b0;
            ref_addr[c]  = '0;
        end
        ref_last = NCLI - 1;
    endtask

    task automatic apply();
        for (int c = 0; c < NCLI; c++) begin
            cli_cs[c]            = drv_cs[c];
            cli_addr[c*AW +: AW] = drv_addr[c];
        end
    endtask

    task automatic idle_all();
        for (int c = 0; c < NCLI; c++) drv_cs[c] = 1'b0;
        apply();
    endtask

    task automatic wait_req(output bit got);
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (sdram_req) got = 1'b1;
        end
    endtask

    // SDRAM side: ack ack_dly cycles after req is seen, rdy rdy_dly cycles after ack
    task automatic serve(input int ack_dly, input int rdy_dly,
                         output logic [AW-1:0] a, output bit got);
        a = '0;
        wait_req(got);
        if (!got) return;
        a = sdram_addr;
        repeat (ack_dly) @(negedge clk);
        sdram_ack = 1'b1;
        if (rdy_dly == 0) begin
            sdram_rdy  = 1'b1;
            sdram_data = mem(a);
        end
        @(negedge clk);
        sdram_ack = 1'b0;
        sdram_rdy = 1'b0;
        if (rdy_dly > 0) begin
            repeat (rdy_dly - 1) @(negedge clk);
            sdram_rdy  = 1'b1;
            sdram_data = mem(a);
            @(negedge clk);
            sdram_rdy = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_all();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        ref_clear();
    endtask

    task automatic test_reset();
        for (int c = 0; c < NCLI; c++) drv_addr[c] = '0;
        do_reset();
        @(negedge clk);
        checks++; if (cli_ok !== 4'b0) begin errors++; $display("FAIL reset_ok got %b exp 0", cli_ok); end
        checks++; if (cli_data !== '0) begin errors++; $display("FAIL reset_data got %h exp 0", cli_data); end
        checks++; if (sdram_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", sdram_req); end
        checks++; if (sdram_addr !== '0) begin errors++; $display("FAIL reset_addr got %h exp 0", sdram_addr); end
    endtask

    task automatic test_first_miss();
        logic [AW-1:0] a;
        bit got;
        drv_cs[0] = 1'b1; drv_addr[0] = 22'h000100;
        apply();
        serve(1, 3, a, got);
        checks++; if (!got) begin errors++; $display("FAIL miss_req_timeout got 0 exp 1"); end
        checks++; if (a !== 22'h000100) begin errors++; $display("FAIL miss_addr got %h exp 000100", a); end
        ref_grant(0, 22'h000100);
        checks++; if (cli_ok[0] !== 1'b1) begin errors++; $display("FAIL miss_ok got %b exp 1", cli_ok[0]); end
        checks++; if (cli_data[7:0] !== 8'hA5) begin errors++; $display("FAIL miss_data got %h exp a5", cli_data[7:0]); end
        checks++; if (sdram_req !== 1'b0) begin errors++; $display("FAIL miss_req_drop got %b exp 0", sdram_req); end
    endtask

    task automatic test_hit();
        int pulses;
        idle_all();
        @(negedge clk);
        checks++; if (cli_ok[0] !== 1'b0) begin errors++; $display("FAIL hit_ok_drop got %b exp 0", cli_ok[0]); end
        pulses = req_pulses;
        drv_cs[0] = 1'b1;
        apply();
        @(negedge clk);
        checks++; if (cli_ok[0] !== 1'b1) begin errors++; $display("FAIL hit_ok got %b exp 1", cli_ok[0]); end
        checks++; if (cli_data[7:0] !== 8'hA5) begin errors++; $display("FAIL hit_data got %h exp a5", cli_data[7:0]); end
        repeat (4) @(negedge clk);
        checks++; if (req_pulses !== pulses) begin errors++; $display("FAIL hit_no_req got %0d exp %0d", req_pulses, pulses); end
    endtask

    task automatic test_priority();
        logic [AW-1:0] a;
        bit got;
        int w;
        idle_all();
        drv_cs[1] = 1'b1; drv_addr[1] = 22'h001100;
        drv_cs[3] = 1'b1; drv_addr[3] = 22'h003300;
        apply();
        for (int n = 0; n < 2; n++) begin
            w = ref_pick();
            serve(2, 2, a, got);
            checks++; if (!got || w < 0 || a !== drv_addr[w]) begin errors++; $display("FAIL prio_order%0d got %h exp %h", n, a, (w < 0) ? '0 : drv_addr[w]); end
            if (w >= 0) ref_grant(w, drv_addr[w]);
        end
        checks++; if (cli_ok !== 4'b1010) begin errors++; $display("FAIL prio_ok got %b exp 1010", cli_ok); end
        checks++; if (cli_data[31:24] !== mem(22'h003300)) begin errors++; $display("FAIL prio_data3 got %h exp %h", cli_data[31:24], mem(22'h003300)); end
    endtask

    task automatic test_addr_change();
        logic [AW-1:0] a;
        bit got;
        idle_all();
        drv_cs[2] = 1'b1; drv_addr[2] = 22'h000020;
        apply();
        wait_req(got);
        checks++; if (!got || sdram_addr !== 22'h000020) begin errors++; $display("FAIL chg_first_addr got %h exp 000020", sdram_addr); end
        sdram_ack = 1'b1;
        @(negedge clk);
        sdram_ack = 1'b0;
        drv_addr[2] = 22'h000021;
        apply();
        @(negedge clk);
        sdram_rdy = 1'b1; sdram_data = mem(22'h000020);
        @(negedge clk);
        sdram_rdy = 1'b0;
        ref_grant(2, 22'h000020);
        checks++; if (cli_ok[2] !== 1'b0) begin errors++; $display("FAIL chg_ok_stale got %b exp 0", cli_ok[2]); end
        @(negedge clk);
        checks++; if (sdram_req !== 1'b1 || sdram_addr !== 22'h000021) begin errors++; $display("FAIL chg_rerequest got req=%b addr=%h exp req=1 addr=000021", sdram_req, sdram_addr); end
        serve(1, 1, a, got);
        ref_grant(2, 22'h000021);
        checks++; if (cli_ok[2] !== 1'b1 || cli_data[23:16] !== mem(22'h000021)) begin errors++; $display("FAIL chg_refill got ok=%b data=%h exp ok=1 data=%h", cli_ok[2], cli_data[23:16], mem(22'h000021)); end
    endtask

    task automatic test_reset_mid();
        logic [AW-1:0] a;
        bit got;
        idle_all();
        drv_cs[0] = 1'b1; drv_addr[0] = 22'h000300;
        apply();
        wait_req(got);
        sdram_ack = 1'b1;
        @(negedge clk);
        sdram_ack = 1'b0;
        rst = 1'b1;
        idle_all();
        @(negedge clk);
        rst = 1'b0;
        ref_clear();
        @(negedge clk);
        sdram_rdy = 1'b1; sdram_data = mem(22'h000300);
        @(negedge clk);
        sdram_rdy = 1'b0;
        @(negedge clk);
        checks++; if (cli_ok !== 4'b0 || sdram_req !== 1'b0) begin errors++; $display("FAIL rstmid_idle got ok=%b req=%b exp ok=0 req=0", cli_ok, sdram_req); end
        checks++; if (cli_data !== '0) begin errors++; $display("FAIL rstmid_data got %h exp 0", cli_data); end
        drv_cs[0] = 1'b1;
        apply();
        repeat (2) @(negedge clk);
        checks++; if (sdram_req !== 1'b1 || cli_ok[0] !== 1'b0) begin errors++; $display("FAIL rstmid_slot_invalid got req=%b ok=%b exp req=1 ok=0", sdram_req, cli_ok[0]); end
        serve(0, 2, a, got);
        ref_grant(0, 22'h000300);
    endtask

    task automatic test_ack_rdy_same();
        logic [AW-1:0] a;
        bit got;
        idle_all();
        drv_cs[1] = 1'b1; drv_addr[1] = 22'h004444;
        apply();
        serve(2, 0, a, got);
        ref_grant(1, 22'h004444);
        checks++; if (cli_ok[1] !== 1'b1 || cli_data[15:8] !== mem(22'h004444)) begin errors++; $display("FAIL same_fill got ok=%b data=%h exp ok=1 data=%h", cli_ok[1], cli_data[15:8], mem(22'h004444)); end
        drv_cs[3] = 1'b1; drv_addr[3] = 22'h005555;
        apply();
        @(negedge clk);
        checks++; if (sdram_req !== 1'b1 || sdram_addr !== 22'h005555) begin errors++; $display("FAIL same_idle got req=%b addr=%h exp req=1 addr=005555", sdram_req, sdram_addr); end
        serve(1, 1, a, got);
        ref_grant(3, 22'h005555);
    endtask

    task automatic test_random();
        logic [AW-1:0] pool [6];
        logic [AW-1:0] a;
        bit got;
        int w;
        pool[0] = 22'h000100; pool[1] = 22'h000020; pool[2] = 22'h3FFFFF;
        pool[3] = 22'h012345; pool[4] = 22'h000021; pool[5] = 22'h2ABCDE;
        for (int it = 0; it < 40; it++) begin
            for (int c = 0; c < NCLI; c++) begin
                drv_cs[c]   = 1'($urandom_range(0, 1));
                drv_addr[c] = pool[$urandom_range(0, 5)];
            end
            apply();
            for (int g = 0; g < 2 * NCLI; g++) begin
                w = ref_pick();
                if (w < 0) break;
                serve($urandom_range(0, 3), $urandom_range(0, 3), a, got);
                checks++; if (!got || a !== drv_addr[w]) begin errors++; $display("FAIL rnd_grant it=%0d got %h exp %h", it, a, drv_addr[w]); end
                ref_grant(w, drv_addr[w]);
            end
            @(negedge clk);
            for (int c = 0; c < NCLI; c++) begin
                checks++;
                if (cli_ok[c] !== (drv_cs[c] && ref_hit(c))) begin
                    errors++; $display("FAIL rnd_ok it=%0d cli=%0d got %b exp %b", it, c, cli_ok[c], drv_cs[c] && ref_hit(c));
                end else if (cli_ok[c] && cli_data[c*DW +: DW] !== mem(drv_addr[c])) begin
                    errors++; $display("FAIL rnd_data it=%0d cli=%0d got %h exp %h", it, c, cli_data[c*DW +: DW], mem(drv_addr[c]));
                end
            end
        end
    endtask

    initial begin
        for (int c = 0; c < NCLI; c++) begin
            drv_cs[c]   = 1'b0;
            drv_addr[c] = '0;
        end
        ref_clear();
        test_reset();
        test_first_miss();
        test_hit();
        test_priority();
        test_addr_change();
        test_reset_mid();
        test_ack_rdy_same();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
